bht_ctrl: RTL and testbench

Branch history table controller for the pipelined core: owns a table of 2-bit saturating counters and sequences access to it. It serves a combinational prediction read to the fetch stage and a registered outcome update from the branch-resolve (MEM) stage. It also runs a multi-cycle initialisation sweep after reset or flush. Optional statistics counters expose commit and mispredict totals, so benches and firmware need no hierarchical probing.

---
 rtl/bht_ctrl_if.sv | 40 ++++
 rtl/bht_ctrl.sv | 117 +++++++++++
 tb/tb_bht_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bht_ctrl_if.sv
// ---------------------------------------------------------------------------
// bht_ctrl_if
// Bundles the fetch-stage prediction port, the resolve-stage update port,
// the flush/ready handshake and the statistics outputs of bht_ctrl.
//   master : the pipeline side (drives pcs, updates, flush)
//   slave  : the branch history table controller
// Signals:
//   flush_req        pipeline -> bht  one-cycle pulse restarting the sweep
//   ready            bht -> pipeline  table valid and accepting traffic
//   pred_pc          pipeline -> bht  fetch-stage pc
//   pred_taken       bht -> pipeline  predicted direction for pred_pc
//   upd_valid        pipeline -> bht  conditional branch resolved
//   upd_pc           pipeline -> bht  pc of resolved branch
//   upd_taken        pipeline -> bht  actual outcome
//   upd_mispredict   pipeline -> bht  resolve stage saw a wrong direction
//   stat_commits     bht -> pipeline  resolved branch total
//   stat_mispredicts bht -> pipeline  mispredict total
// ---------------------------------------------------------------------------
interface bht_ctrl_if;
  logic        flush_req;
  logic        ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [31:0] stat_commits;
  logic [31:0] stat_mispredicts;

  modport master (
    output flush_req, pred_pc, upd_valid, upd_pc, upd_taken, upd_mispredict,
    input  ready, pred_taken, stat_commits, stat_mispredicts
  );

  modport slave (
    input  flush_req, pred_pc, upd_valid, upd_pc, upd_taken, upd_mispredict,
    output ready, pred_taken, stat_commits, stat_mispredicts
  );
endinterface

// File: rtl/bht_ctrl.sv
// ---------------------------------------------------------------------------
// bht_ctrl
// Branch history table of 2-bit saturating counters. Serves a combinational
// prediction to fetch, a registered outcome update from the resolve stage,
// and a one-entry-per-cycle initialisation sweep after reset or flush.
// Ports:
//   clk  core clock, all state changes on posedge
//   rst  synchronous active-high reset
//   bus  bht_ctrl_if.slave (prediction, update, flush/ready, statistics)
// Parameters:
//   INDEX_BITS  log2 of the entry count; index = pc[INDEX_BITS+1:2]
//   INIT_STATE  counter value written by the sweep
// Optional feature macro:
//   BHT_STATS_EN  builds commit/mispredict counters; otherwise the stat
//                 outputs are tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module bht_ctrl #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input logic       clk,
  input logic       rst,
  bht_ctrl_if.slave bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state, state_next;
  logic [INDEX_BITS-1:0] ptr;
  logic [1:0]            cnt_table [ENTRIES];
  logic [INDEX_BITS-1:0] pred_idx, upd_idx;
  logic [1:0]            upd_cur, upd_new, pred_cur;
  logic                  upd_en;
  logic                  pc_unused;

  assign pred_idx = bus.pred_pc[INDEX_BITS+1:2];
  assign upd_idx  = bus.upd_pc[INDEX_BITS+1:2];

  // Only the index field of each pc selects an entry; aliasing is intended.
  assign pc_unused = ^{bus.pred_pc[31:INDEX_BITS+2], bus.pred_pc[1:0],
                       bus.upd_pc[31:INDEX_BITS+2], bus.upd_pc[1:0]};

  // An update lands only in RUN and loses to both reset and flush.
  assign upd_en = (state == RUN) && bus.upd_valid && !bus.flush_req && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT: if (!bus.flush_req && ptr == LAST_IDX) state_next = RUN;
      RUN:  if (bus.flush_req) state_next = INIT;
    endcase
  end

  // Sweep pointer wraps back to zero after the last entry, so it is already
  // cleared for the next sweep when RUN is entered.
  always_ff @(posedge clk) begin
    if (rst)                ptr <= '0;
    else if (bus.flush_req) ptr <= '0;
    else if (state == INIT) ptr <= ptr + 1'b1;
  end

  always_comb begin
    upd_cur = cnt_table[upd_idx];
    upd_new = upd_cur;
    if (bus.upd_taken && upd_cur != 2'd3)       upd_new = upd_cur + 2'd1;
    else if (!bus.upd_taken && upd_cur != 2'd0) upd_new = upd_cur - 2'd1;
  end

  // Table storage has no reset; the sweep is what makes it valid.
  always_ff @(posedge clk) begin
    if (state == INIT && !rst) cnt_table[ptr] <= INIT_STATE;
    else if (upd_en)           cnt_table[upd_idx] <= upd_new;
  end

  // Same-cycle bypass lets fetch see an update resolving this very cycle.
  always_comb begin
    pred_cur = cnt_table[pred_idx];
    if (upd_en && upd_idx == pred_idx) pred_cur = upd_new;
  end

  assign bus.pred_taken = (state == RUN) && pred_cur[1];
  assign bus.ready      = (state == RUN);

`ifdef BHT_STATS_EN
  logic [31:0] commits_q, mispredicts_q;

  // Statistics survive flushes and only clear on reset; both saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      commits_q     <= '0;
      mispredicts_q <= '0;
    end else if (upd_en) begin
      if (commits_q != 32'hFFFF_FFFF) commits_q <= commits_q + 32'd1;
      if (bus.upd_mispredict && mispredicts_q != 32'hFFFF_FFFF)
        mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign bus.stat_commits     = commits_q;
  assign bus.stat_mispredicts = mispredicts_q;
`else
  logic stat_unused;

  assign stat_unused          = bus.upd_mispredict;
  assign bus.stat_commits     = '0;
  assign bus.stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_bht_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bht_ctrl
// Directed bench for bht_ctrl at default parameters (64 entries, init value
// weakly not-taken). Expected values are pushed to a scoreboard queue as
// each step is driven and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_bht_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  bht_ctrl_if bus ();

  bht_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record what the next sampled output is required to be.
  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the sampled value.
  task automatic check_output(input logic [31:0] observed);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.val)
      else begin
        n_fail++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.val);
      end
    end
  endtask

  task automatic apply_stimulus(input logic fl, input logic uv,
                                input logic [31:0] upc, input logic ut,
                                input logic um, input logic [31:0] ppc);
    bus.flush_req      = fl;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_taken      = ut;
    bus.upd_mispredict = um;
    bus.pred_pc        = ppc;
  endtask

  // One clock cycle: drive, sample ready/pred_taken mid-cycle, advance.
  task automatic step(input string tag, input logic fl, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic um,
                      input logic [31:0] ppc, input logic exp_ready,
                      input logic exp_pred);
    apply_stimulus(fl, uv, upc, ut, um, ppc);
    push_exp({tag, "_ready"}, {31'd0, exp_ready});
    push_exp({tag, "_pred"},  {31'd0, exp_pred});
    @(negedge clk);
    check_output({31'd0, bus.ready});
    check_output({31'd0, bus.pred_taken});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [31:0] ppc,
                      input logic exp_ready, input logic exp_pred);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, ppc, exp_ready, exp_pred);
  endtask

  task automatic check_stats(input string tag, input logic [31:0] commits,
                             input logic [31:0] mispredicts);
`ifdef BHT_STATS_EN
    push_exp({tag, "_commits"},     commits);
    push_exp({tag, "_mispredicts"}, mispredicts);
`else
    push_exp({tag, "_commits"},     32'd0);
    push_exp({tag, "_mispredicts"}, 32'd0);
`endif
    check_output(bus.stat_commits);
    check_output(bus.stat_mispredicts);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset state
    @(posedge clk);
    #1;
    push_exp("reset_ready", 32'd0);
    push_exp("reset_pred",  32'd0);
    check_output({31'd0, bus.ready});
    check_output({31'd0, bus.pred_taken});
    check_stats("reset", 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Initial sweep: 64 not-ready cycles; two updates to 0x0C are ignored
    for (int k = 0; k < 64; k++) begin
      if (k == 10 || k == 11)
        step("init_upd", 1'b0, 1'b1, 32'h0C, 1'b1, 1'b1, 32'(k * 4), 1'b0, 1'b0);
      else
        idle("init", 32'(k * 4), 1'b0, 1'b0);
    end

    // Every pc in the table reads weakly not-taken once ready
    for (int k = 0; k < 64; k++)
      idle("run_pc_sweep", 32'(k * 4), 1'b1, 1'b0);
    check_stats("after_init", 32'd0, 32'd0);

    // Saturation on 0x40 with bypass: 1->2->3->3->3
    step("sat_t1", 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1);
    step("sat_t2", 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1);
    step("sat_t3", 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1);
    step("sat_t4", 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1);
    idle("sat_hold3", 32'h40, 1'b1, 1'b1);
    // 3->2 still predicts taken, then 2->1->0
    step("sat_n1", 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    idle("sat_hold2", 32'h40, 1'b1, 1'b1);
    step("sat_n2", 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0);
    step("sat_n3", 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0);
    idle("sat_hold0", 32'h40, 1'b1, 1'b0);

    // Non-bypassed reads see the write one cycle later: 0->1->2
    step("nb_t1", 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
    idle("nb_read1", 32'h40, 1'b1, 1'b0);
    step("nb_t2", 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
    idle("nb_read2", 32'h40, 1'b1, 1'b1);

    // Bypass: 0x80 at 1, taken update is visible in the same cycle
    idle("byp_before", 32'h80, 1'b1, 1'b0);
    step("byp_same", 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1);
    idle("byp_after", 32'h80, 1'b1, 1'b1);

    // Aliasing: 0x04 and 0x104 share an entry
    step("alias_t1", 1'b0, 1'b1, 32'h04, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
    step("alias_t2", 1'b0, 1'b1, 32'h04, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
    idle("alias_read", 32'h104, 1'b1, 1'b1);

    // Updates during the first sweep left 0x0C untouched
    idle("init_upd_ignored", 32'h0C, 1'b1, 1'b0);

    // Train 0x40 from 2 to 3
    step("flush_train", 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1);
    check_stats("pre_flush", 32'd13, 32'd3);

    // Flush with a concurrent update: update dropped, ready low next cycle
    step("flush_pulse", 1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    // Restart the sweep partway through by a second flush
    for (int k = 0; k < 20; k++)
      idle("flush_init_a", 32'h40, 1'b0, 1'b0);
    step("flush_in_init", 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
    for (int k = 0; k < 64; k++)
      idle("flush_init_b", 32'h40, 1'b0, 1'b0);
    idle("flush_done", 32'h40, 1'b1, 1'b0);
    idle("flush_other", 32'h80, 1'b1, 1'b0);
    check_stats("post_flush", 32'd13, 32'd3);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
